vec_issue_seq: RTL and testbench
================================

Name: vec_issue_seq

Overview:
Vector issue sequencer in the ID stage, directly upstream of the ID/EXE pipeline register. It expands one decoded vector instruction into one element issue per cycle. For each element it drives the per-element state code, the element counter and the element register addresses into ID/EXE. It freezes fetch and IF/ID until the last element has issued. Scalar instructions pass through in one cycle.

Parameters:
CNT_W, 5, element counter / vector-length width (max 32 elements)
ADDR_W, 5, register address width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
id_valid  in  1  decoded instruction present in ID
id_is_vec  in  1  decoded instruction is a vector op
id_vlen  in  CNT_W  element count minus one (0..31)
id_rs_addr  in  ADDR_W  base rs address
id_rt_addr  in  ADDR_W  base rt address
id_rd_addr  in  ADDR_W  base rd address
hold  in  1  downstream stall; sequencer registers freeze
flush  in  1  branch/jump flush of ID
next_state  out  2  state code to ID/EXE: 0 bubble, 1 scalar, 2 vector element, 3 vector last element
seq_cnt  out  CNT_W  element index to ID/EXE cnt_i
seq_rs_addr  out  ADDR_W  element rs address
seq_rt_addr  out  ADDR_W  element rt address
seq_rd_addr  out  ADDR_W  element rd address
fetch_stall  out  1  freeze PC and IF/ID
busy  out  1  multi-element vector op in progress

Behaviour:
- Reset is synchronous and active-high. It clears all registers: st=IDLE, cnt=0, vlen_q=0, base_rs/rt/rd_q=0.
- Internal FSM has two states, IDLE and RUN. Outputs are combinational from the registers and, in IDLE, from the id_* inputs.
- Any cycle with flush=1:
  - next_state=0 and fetch_stall=0.
  - Next edge: st<=IDLE, cnt<=0.
  - flush has priority over hold and over all other transitions.
- IDLE, id_valid=0: next_state=0. seq_cnt=0. Address outputs = id_* passthrough. fetch_stall=0.
- IDLE, scalar (id_valid=1, id_is_vec=0): next_state=1, seq_cnt=0, address passthrough, fetch_stall=0. Stays in IDLE.
- IDLE, vector with id_vlen=0: next_state=3, seq_cnt=0, address passthrough, fetch_stall=0. Stays in IDLE.
- IDLE, vector with id_vlen>0:
  - Outputs: next_state=2, seq_cnt=0, address passthrough (element 0), fetch_stall=1.
  - If hold=0, next edge: st<=RUN, cnt<=1, capture vlen_q and the three base addresses.
  - If hold=1, registers are unchanged. The instruction is re-presented because fetch_stall keeps IF/ID frozen.
- RUN:
  - seq_cnt=cnt.
  - Element address = base_q + cnt, truncated to ADDR_W (wrap 31->0).
  - next_state = (cnt==vlen_q) ? 3 : 2.
  - fetch_stall = (cnt!=vlen_q). On the last element, fetch is released so the next instruction is in ID on the following cycle.
  - id_* inputs are ignored.
- RUN, hold=0: if cnt==vlen_q then st<=IDLE, cnt<=0; else cnt<=cnt+1.
- RUN, hold=1: cnt and st are frozen. Outputs are unchanged, so the same element is re-presented.
- busy = (st==RUN).
- Latency: an N-element vector op occupies ID for exactly N non-hold cycles. It emits N consecutive next_state codes: 2,...,2,3.
- Reset mid-operation behaves like flush: the sequencer returns to IDLE and any partially issued vector op is abandoned.

Test Plan:
- Scalar: id_valid=1, id_is_vec=0, rs=3, rt=4, rd=5 -> same cycle next_state=1, seq_cnt=0, addresses 3/4/5, fetch_stall=0, busy=0.
- Vector vlen=3, base rs=8, rt=16, rd=24 -> 4 cycles: next_state 2,2,2,3; seq_cnt 0,1,2,3; rd 24..27; fetch_stall 1,1,1,0; busy 0,1,1,1; then IDLE.
- Wrap: vlen=4, base rd=30 -> rd sequence 30,31,0,1,2.
- Hold: vlen=2, hold=1 for 2 cycles while cnt=1 -> seq_cnt stays 1 with next_state=2 for 3 cycles, then 2 (next_state=3); total 5 cycles.
- Flush at cnt=2 of vlen=5 -> that cycle next_state=0, fetch_stall=0; next cycle busy=0 and a scalar on id_* issues with next_state=1.
- vlen=0 vector, and rst=1 asserted while in RUN -> vlen=0 gives single cycle next_state=3, fetch_stall=0; rst gives next cycle st=IDLE, seq_cnt=0, busy=0.

Source files
------------

// File: rtl/vec_issue_seq.sv
// Vector issue sequencer in ID: expands one decoded vector op into one element
// issue per cycle toward ID/EXE and holds fetch until the last element goes out.
//
// state | meaning
// IDLE  | scalar/bubble pass-through; element 0 of a vector op is issued from id_*
// RUN   | issuing elements 1..vlen from the captured base addresses
module vec_issue_seq #(
  parameter int CNT_W  = 5,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_is_vec,
  input  logic [CNT_W-1:0]  id_vlen,
  input  logic [ADDR_W-1:0] id_rs_addr,
  input  logic [ADDR_W-1:0] id_rt_addr,
  input  logic [ADDR_W-1:0] id_rd_addr,
  input  logic              hold,
  input  logic              flush,
  output logic [1:0]        next_state,
  output logic [CNT_W-1:0]  seq_cnt,
  output logic [ADDR_W-1:0] seq_rs_addr,
  output logic [ADDR_W-1:0] seq_rt_addr,
  output logic [ADDR_W-1:0] seq_rd_addr,
  output logic              fetch_stall,
  output logic              busy
);

  localparam logic [1:0] NS_BUBBLE = 2'd0;
  localparam logic [1:0] NS_SCALAR = 2'd1;
  localparam logic [1:0] NS_VEC    = 2'd2;
  localparam logic [1:0] NS_LAST   = 2'd3;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             st, st_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [CNT_W-1:0]   vlen_q, vlen_nxt;
  logic [ADDR_W-1:0]  base_rs_q, base_rt_q, base_rd_q;
  logic [ADDR_W-1:0]  base_rs_nxt, base_rt_nxt, base_rd_nxt;
  logic [ADDR_W-1:0]  cnt_addr;
  logic               last_elem;

  assign cnt_addr  = ADDR_W'(cnt);
  assign last_elem = (cnt == vlen_q);
  assign busy      = (st == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      cnt       <= '0;
      vlen_q    <= '0;
      base_rs_q <= '0;
      base_rt_q <= '0;
      base_rd_q <= '0;
    end else begin
      st        <= st_nxt;
      cnt       <= cnt_nxt;
      vlen_q    <= vlen_nxt;
      base_rs_q <= base_rs_nxt;
      base_rt_q <= base_rt_nxt;
      base_rd_q <= base_rd_nxt;
    end
  end

  always_comb begin
    st_nxt      = st;
    cnt_nxt     = cnt;
    vlen_nxt    = vlen_q;
    base_rs_nxt = base_rs_q;
    base_rt_nxt = base_rt_q;
    base_rd_nxt = base_rd_q;
    next_state  = NS_BUBBLE;
    seq_cnt     = cnt;
    seq_rs_addr = base_rs_q + cnt_addr;
    seq_rt_addr = base_rt_q + cnt_addr;
    seq_rd_addr = base_rd_q + cnt_addr;
    fetch_stall = 1'b0;

    case (st)
      IDLE: begin
        seq_cnt     = '0;
        seq_rs_addr = id_rs_addr;
        seq_rt_addr = id_rt_addr;
        seq_rd_addr = id_rd_addr;
        if (id_valid) begin
          if (!id_is_vec) begin
            next_state = NS_SCALAR;
          end else if (id_vlen == '0) begin
            next_state = NS_LAST;
          end else begin
            next_state  = NS_VEC;
            fetch_stall = 1'b1;
            if (!hold) begin
              st_nxt      = RUN;
              cnt_nxt     = CNT_W'(1);
              vlen_nxt    = id_vlen;
              base_rs_nxt = id_rs_addr;
              base_rt_nxt = id_rt_addr;
              base_rd_nxt = id_rd_addr;
            end
          end
        end
      end
      RUN: begin
        next_state  = last_elem ? NS_LAST : NS_VEC;
        fetch_stall = !last_elem;
        if (!hold) begin
          if (last_elem) begin
            st_nxt  = IDLE;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: st_nxt = IDLE;
    endcase

    // Flush beats hold and any capture that IDLE would otherwise perform.
    if (flush) begin
      next_state  = NS_BUBBLE;
      fetch_stall = 1'b0;
      st_nxt      = IDLE;
      cnt_nxt     = '0;
      vlen_nxt    = vlen_q;
      base_rs_nxt = base_rs_q;
      base_rt_nxt = base_rt_q;
      base_rd_nxt = base_rd_q;
    end
  end

endmodule

// File: tb/tb_vec_issue_seq.sv
// Scoreboard bench for vec_issue_seq: stimulus pushes hand-computed expectations
// per cycle, a negedge monitor pops and compares them against the DUT outputs.
module tb_vec_issue_seq;

  logic       clk = 1'b0;
  logic       rst, id_valid, id_is_vec, hold, flush;
  logic [4:0] id_vlen, id_rs_addr, id_rt_addr, id_rd_addr;
  logic [1:0] next_state;
  logic [4:0] seq_cnt, seq_rs_addr, seq_rt_addr, seq_rd_addr;
  logic       fetch_stall, busy;

  typedef struct {
    string      tag;
    logic       chk;
    logic [1:0] ns;
    logic [4:0] cnt, rs, rt, rd;
    logic       fs, bsy;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  vec_issue_seq #(.CNT_W(5), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_is_vec(id_is_vec),
    .id_vlen(id_vlen), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rd_addr(id_rd_addr), .hold(hold), .flush(flush),
    .next_state(next_state), .seq_cnt(seq_cnt), .seq_rs_addr(seq_rs_addr),
    .seq_rt_addr(seq_rt_addr), .seq_rd_addr(seq_rd_addr),
    .fetch_stall(fetch_stall), .busy(busy)
  );

  task automatic cmp(input string tag, input string fld, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s.%s actual=%0d required=%0d", tag, fld, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.chk) begin
        cmp(e.tag, "next_state",  next_state,  e.ns);
        cmp(e.tag, "seq_cnt",     seq_cnt,     e.cnt);
        cmp(e.tag, "seq_rs_addr", seq_rs_addr, e.rs);
        cmp(e.tag, "seq_rt_addr", seq_rt_addr, e.rt);
        cmp(e.tag, "seq_rd_addr", seq_rd_addr, e.rd);
        cmp(e.tag, "fetch_stall", fetch_stall, e.fs);
        cmp(e.tag, "busy",        busy,        e.bsy);
      end
    end
  end

  task automatic drv(input logic r, input logic v, input logic iv, input logic [4:0] vl,
                     input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                     input logic h, input logic f);
    rst = r; id_valid = v; id_is_vec = iv; id_vlen = vl;
    id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd; hold = h; flush = f;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] ns, input logic [4:0] cnt,
                            input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic fs, input logic bsy);
    exp_t e;
    e.tag = tag; e.chk = 1'b1; e.ns = ns; e.cnt = cnt;
    e.rs = rs; e.rt = rt; e.rd = rd; e.fs = fs; e.bsy = bsy;
    sb.push_back(e);
  endtask

  task automatic skip_out();
    exp_t e;
    e.tag = "skip"; e.chk = 1'b0; e.ns = '0; e.cnt = '0;
    e.rs = '0; e.rt = '0; e.rd = '0; e.fs = 1'b0; e.bsy = 1'b0;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    // reset held: registers cleared, bubble with passthrough addresses
    drv(1, 0, 0, 0, 6, 7, 1, 0, 0); expect_out("reset", 0, 0, 6, 7, 1, 0, 0); tick();

    drv(0, 1, 0, 0, 3, 4, 5, 0, 0); expect_out("scalar", 1, 0, 3, 4, 5, 0, 0); tick();

    // vlen=3, id_* scrambled during RUN to show they are ignored
    drv(0, 1, 1, 3,  8, 16, 24, 0, 0); expect_out("vec3_e0", 2, 0,  8, 16, 24, 1, 0); tick();
    drv(0, 1, 1, 9, 20, 21, 22, 0, 0); expect_out("vec3_e1", 2, 1,  9, 17, 25, 1, 1); tick();
    drv(0, 0, 0, 1,  1,  1,  1, 0, 0); expect_out("vec3_e2", 2, 2, 10, 18, 26, 1, 1); tick();
    drv(0, 1, 0, 7,  2,  2,  2, 0, 0); expect_out("vec3_e3", 3, 3, 11, 19, 27, 0, 1); tick();
    drv(0, 0, 0, 0, 13, 14, 15, 0, 0); expect_out("vec3_idle", 0, 0, 13, 14, 15, 0, 0); tick();

    // address wrap 31 -> 0
    drv(0, 1, 1, 4, 0, 0, 30, 0, 0); expect_out("wrap_e0", 2, 0, 0, 0, 30, 1, 0); tick();
    expect_out("wrap_e1", 2, 1, 1, 1, 31, 1, 1); tick();
    expect_out("wrap_e2", 2, 2, 2, 2,  0, 1, 1); tick();
    expect_out("wrap_e3", 2, 3, 3, 3,  1, 1, 1); tick();
    expect_out("wrap_e4", 3, 4, 4, 4,  2, 0, 1); tick();

    // hold in RUN for two cycles at cnt=1
    drv(0, 1, 1, 2, 1, 2, 3, 0, 0); expect_out("hold_e0", 2, 0, 1, 2, 3, 1, 0); tick();
    hold = 1; expect_out("hold_h1", 2, 1, 2, 3, 4, 1, 1); tick();
    expect_out("hold_h2", 2, 1, 2, 3, 4, 1, 1); tick();
    hold = 0; expect_out("hold_e1", 2, 1, 2, 3, 4, 1, 1); tick();
    expect_out("hold_e2", 3, 2, 3, 4, 5, 0, 1); tick();

    // hold while a vector sits in IDLE: no capture, instruction re-presented
    drv(0, 1, 1, 1, 4, 5, 6, 1, 0); expect_out("ihold_0", 2, 0, 4, 5, 6, 1, 0); tick();
    hold = 0; expect_out("ihold_1", 2, 0, 4, 5, 6, 1, 0); tick();
    expect_out("ihold_e1", 3, 1, 5, 6, 7, 0, 1); tick();

    // flush (with hold asserted) at cnt=2 of vlen=5
    drv(0, 1, 1, 5, 0, 0, 10, 0, 0); expect_out("flush_e0", 2, 0, 0, 0, 10, 1, 0); tick();
    expect_out("flush_e1", 2, 1, 1, 1, 11, 1, 1); tick();
    hold = 1; flush = 1; expect_out("flush_cyc", 0, 2, 2, 2, 12, 0, 1); tick();
    drv(0, 1, 0, 0, 3, 4, 5, 0, 0); expect_out("flush_after", 1, 0, 3, 4, 5, 0, 0); tick();

    drv(0, 1, 1, 0, 7, 8, 9, 0, 0); expect_out("vlen0", 3, 0, 7, 8, 9, 0, 0); tick();
    drv(0, 0, 0, 0, 7, 8, 9, 0, 0); expect_out("vlen0_after", 0, 0, 7, 8, 9, 0, 0); tick();

    // reset mid-RUN abandons the op
    drv(0, 1, 1, 5, 0, 0, 0, 0, 0); expect_out("rst_e0", 2, 0, 0, 0, 0, 1, 0); tick();
    expect_out("rst_e1", 2, 1, 1, 1, 1, 1, 1); tick();
    rst = 1; skip_out(); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_out("rst_after", 0, 0, 0, 0, 0, 0, 0); tick();

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
